// File: rtl/axil_cmd_arbiter_if.sv
// axil_cmd_arbiter_if: requester command/response and master user-command signals for the arbiter
interface axil_cmd_arbiter_if #(
   parameter int NUM_REQ    = 2,
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   logic [NUM_REQ-1:0]            req_valid;
   logic [NUM_REQ-1:0]            req_we;
   logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
   logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;
   logic [NUM_REQ-1:0]            req_ready;
   logic [NUM_REQ-1:0]            rsp_valid;
   logic [DATA_WIDTH-1:0]         rsp_rdata;
   logic [1:0]                    rsp_err;
   logic                          busy;
   logic                          init_w_axi_txn;
   logic                          init_r_axi_txn;
   logic [ADDR_WIDTH-1:0]         user_awaddr;
   logic [ADDR_WIDTH-1:0]         user_araddr;
   logic [DATA_WIDTH-1:0]         user_wdata;
   logic                          done_w_axi_txn;
   logic                          done_r_axi_txn;
   logic                          error_w_axi_txn;
   logic                          error_r_axi_txn;
   logic [DATA_WIDTH-1:0]         user_rdata;

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata,
      input  done_w_axi_txn, done_r_axi_txn, error_w_axi_txn, error_r_axi_txn, user_rdata,
      output req_ready, rsp_valid, rsp_rdata, rsp_err, busy,
      output init_w_axi_txn, init_r_axi_txn, user_awaddr, user_araddr, user_wdata
   );

   modport master (
      output req_valid, req_we, req_addr, req_wdata,
      output done_w_axi_txn, done_r_axi_txn, error_w_axi_txn, error_r_axi_txn, user_rdata,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy,
      input  init_w_axi_txn, init_r_axi_txn, user_awaddr, user_araddr, user_wdata
   );
endinterface

// File: rtl/axil_cmd_arbiter.sv
// axil_cmd_arbiter: round-robin sequencer sharing one single-shot AXI-Lite user command port, with watchdog
module axil_cmd_arbiter #(
   parameter int NUM_REQ        = 2,
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input logic M_AXI_ACLK,
   input logic M_AXI_ARESET,
   axil_cmd_arbiter_if.slave bus
);
   localparam int GW = $clog2(NUM_REQ);
   localparam int CW = $clog2(TIMEOUT_CYCLES);

   typedef enum logic [2:0] {IDLE, SETUP, LAUNCH, WAIT, RESP} state_t;

   state_t                state_q, state_d;
   logic [GW-1:0]         last_q, last_d, gnt_q, gnt_d, pick, cand;
   logic                  we_q, we_d, armed_q, armed_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d, araddr_q, araddr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
   logic [1:0]            err_q, err_d;
   logic [NUM_REQ-1:0]    ready, rsp_vld;
   logic                  init_w, init_r, sel_done, sel_err;

   assign sel_done            = we_q ? bus.done_w_axi_txn : bus.done_r_axi_txn;
   assign sel_err             = we_q ? bus.error_w_axi_txn : bus.error_r_axi_txn;
   assign bus.req_ready       = M_AXI_ARESET ? '0 : ready;
   assign bus.rsp_valid       = rsp_vld;
   assign bus.rsp_rdata       = rdata_q;
   assign bus.rsp_err         = err_q;
   assign bus.busy            = state_q != IDLE;
   assign bus.init_w_axi_txn  = init_w;
   assign bus.init_r_axi_txn  = init_r;
   assign bus.user_awaddr     = awaddr_q;
   assign bus.user_araddr     = araddr_q;
   assign bus.user_wdata      = wdata_q;

   // round-robin pick: nearest valid requester after last_q; the lowest offset is written last and wins
   always_comb begin
      pick = last_q;
      cand = last_q;
      for (int i = NUM_REQ; i >= 1; i--) begin
         cand = GW'((int'(last_q) + i) % NUM_REQ);
         if (bus.req_valid[cand]) pick = cand;
      end
   end

   // state and datapath registers
   always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
      if (M_AXI_ARESET) begin
         state_q  <= IDLE;
         last_q   <= GW'(NUM_REQ - 1);
         gnt_q    <= '0;
         we_q     <= 1'b0;
         armed_q  <= 1'b0;
         cnt_q    <= '0;
         awaddr_q <= '0;
         araddr_q <= '0;
         wdata_q  <= '0;
         rdata_q  <= '0;
         err_q    <= '0;
      end else begin
         state_q  <= state_d;
         last_q   <= last_d;
         gnt_q    <= gnt_d;
         we_q     <= we_d;
         armed_q  <= armed_d;
         cnt_q    <= cnt_d;
         awaddr_q <= awaddr_d;
         araddr_q <= araddr_d;
         wdata_q  <= wdata_d;
         rdata_q  <= rdata_d;
         err_q    <= err_d;
      end
   end

   // next-state and pulse outputs; the user_* registers load at grant so they are stable from SETUP on
   always_comb begin
      state_d  = state_q;
      last_d   = last_q;
      gnt_d    = gnt_q;
      we_d     = we_q;
      armed_d  = armed_q;
      cnt_d    = cnt_q;
      awaddr_d = awaddr_q;
      araddr_d = araddr_q;
      wdata_d  = wdata_q;
      rdata_d  = rdata_q;
      err_d    = err_q;
      ready    = '0;
      rsp_vld  = '0;
      init_w   = 1'b0;
      init_r   = 1'b0;
      case (state_q)
         IDLE: if (|bus.req_valid) begin
            ready[pick] = 1'b1;
            gnt_d       = pick;
            we_d        = bus.req_we[pick];
            if (bus.req_we[pick]) begin
               awaddr_d = bus.req_addr[pick*ADDR_WIDTH +: ADDR_WIDTH];
               wdata_d  = bus.req_wdata[pick*DATA_WIDTH +: DATA_WIDTH];
            end else begin
               araddr_d = bus.req_addr[pick*ADDR_WIDTH +: ADDR_WIDTH];
            end
            state_d = SETUP;
         end
         SETUP: state_d = LAUNCH;
         LAUNCH: begin
            init_w  = we_q;
            init_r  = !we_q;
            cnt_d   = '0;
            armed_d = 1'b0;
            state_d = WAIT;
         end
         WAIT: begin
            cnt_d = cnt_q + 1'b1;
            if (!sel_done) armed_d = 1'b1;
            if (armed_q && sel_done) begin
               rdata_d = we_q ? '0 : bus.user_rdata;
               err_d   = {1'b0, sel_err};
               state_d = RESP;
            end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
               rdata_d = '0;
               err_d   = 2'b10;
               state_d = RESP;
            end
         end
         RESP: begin
            rsp_vld[gnt_q] = 1'b1;
            last_d         = gnt_q;
            state_d        = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end
endmodule

// File: tb/tb_axil_cmd_arbiter.sv
// tb_axil_cmd_arbiter: randomized requesters and slave against a transaction-level reference model
module tb_axil_cmd_arbiter;
   localparam int N = 2, AW = 32, DW = 32, TO = 16, BIG = 1 << 30;

   logic clk = 1'b0, rst = 1'b1;
   always #5 clk = ~clk;

   axil_cmd_arbiter_if #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus();

   axil_cmd_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
      .M_AXI_ACLK(clk),
      .M_AXI_ARESET(rst),
      .bus(bus)
   );

   int n_chk = 0, n_fail = 0, cyc = 0;
   logic [N-1:0] vld, we_r, drop;
   logic [AW-1:0] addr [N];
   logic [DW-1:0] wd [N];
   bit auto_gen, rd_force_en;
   int p_new, force_we, force_kind;
   logic [DW-1:0] rd_force;
   bit m_busy;
   int m_last, m_g, init_at, rsp_at;
   logic m_we;
   logic [AW-1:0] m_aw, m_ar;
   logic [DW-1:0] m_wd, e_rdata, h_rdata;
   logic [1:0] e_err, h_err;
   int w_clr, w_set, r_at;
   logic w_err, r_err;
   logic [DW-1:0] r_data;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, got, exp, cyc);
      end
   endtask

   task automatic apply();
      bus.req_valid = vld;
      bus.req_we    = we_r;
      for (int i = 0; i < N; i++) begin
         bus.req_addr[i*AW +: AW]  = addr[i];
         bus.req_wdata[i*DW +: DW] = wd[i];
      end
   endtask

   task automatic model_reset();
      m_busy = 0; m_last = N - 1; m_g = 0; m_we = 0;
      m_aw = '0; m_ar = '0; m_wd = '0; h_rdata = '0; h_err = '0;
      init_at = BIG; rsp_at = BIG; w_clr = BIG; w_set = BIG; r_at = BIG; drop = '0;
      bus.done_w_axi_txn = 0; bus.done_r_axi_txn = 0;
      bus.error_w_axi_txn = 0; bus.error_r_axi_txn = 0; bus.user_rdata = '0;
   endtask

   task automatic drive();
      for (int i = 0; i < N; i++) begin
         if (drop[i]) begin vld[i] = 0; drop[i] = 0; end
         if (auto_gen && !vld[i] && $urandom_range(99) < p_new) begin
            vld[i]  = 1;
            we_r[i] = force_we < 0 ? 1'($urandom_range(1)) : (force_we == 1);
            addr[i] = $urandom;
            wd[i]   = $urandom;
         end
      end
      apply();
      if (cyc == w_clr) bus.done_w_axi_txn = 0;
      if (cyc == w_set) begin bus.done_w_axi_txn = 1; bus.error_w_axi_txn = w_err; end
      bus.done_r_axi_txn = (cyc == r_at) || (cyc == r_at + 1);
      if (cyc == r_at) begin bus.user_rdata = r_data; bus.error_r_axi_txn = r_err; end
   endtask

   task automatic check();
      logic [N-1:0] exp_ready = '0, exp_rsp = '0;
      int g = -1, kind, c, d;
      if (!m_busy && |vld)
         for (int o = 1; o <= N; o++)
            if (g < 0 && vld[(m_last + o) % N]) g = (m_last + o) % N;
      if (g >= 0) exp_ready[g] = 1;
      chk("req_ready", bus.req_ready, exp_ready);
      chk("busy", bus.busy, m_busy);
      chk("init", {bus.init_w_axi_txn, bus.init_r_axi_txn}, cyc == init_at ? (m_we ? 2'b10 : 2'b01) : 2'b00);
      if (cyc == init_at) begin
         chk("user_awaddr", bus.user_awaddr, m_aw);
         chk("user_araddr", bus.user_araddr, m_ar);
         chk("user_wdata", bus.user_wdata, m_wd);
         if (force_kind >= 0) kind = force_kind;
         else begin
            kind = $urandom_range(9);
            kind = kind < 6 ? 0 : kind < 8 ? 1 : 2;
         end
         if (m_we) begin
            c = $urandom_range(1, 3);
            d = $urandom_range(c + 1, TO + 1);
            w_clr = cyc + c;
            w_set = kind == 2 ? BIG : cyc + d;
            w_err = kind == 1;
         end else begin
            d = $urandom_range(2, TO + 1);
            r_at = kind == 2 ? BIG : cyc + d;
            r_err = kind == 1;
            r_data = rd_force_en ? rd_force : $urandom;
         end
         if (kind != 2 && d <= TO) begin
            e_err = {1'b0, kind == 1};
            e_rdata = m_we ? '0 : r_data;
            rsp_at = cyc + d + 1;
         end else begin
            e_err = 2'b10;
            e_rdata = '0;
            rsp_at = cyc + TO + 1;
         end
      end
      if (cyc == rsp_at) exp_rsp[m_g] = 1;
      chk("rsp_valid", bus.rsp_valid, exp_rsp);
      if (cyc == rsp_at) begin
         h_rdata = e_rdata; h_err = e_err; m_last = m_g; m_busy = 0;
         rsp_at = BIG; w_set = BIG; r_at = BIG;
      end
      chk("rsp_rdata", bus.rsp_rdata, h_rdata);
      chk("rsp_err", bus.rsp_err, h_err);
      if (g >= 0) begin
         m_busy = 1; m_g = g; m_we = we_r[g]; drop[g] = 1; init_at = cyc + 2;
         if (we_r[g]) begin m_aw = addr[g]; m_wd = wd[g]; end
         else m_ar = addr[g];
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
      drive();
      @(negedge clk);
      check();
   endtask

   task automatic drain();
      for (int i = 0; i < 300 && (m_busy || |vld); i++) step();
      step();
      chk("drain_idle", bus.busy, 1'b0);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_req_ready"}, bus.req_ready, 0);
      chk({tag, "_rsp_valid"}, bus.rsp_valid, 0);
      chk({tag, "_rsp_rdata"}, bus.rsp_rdata, 0);
      chk({tag, "_rsp_err"}, bus.rsp_err, 0);
      chk({tag, "_busy"}, bus.busy, 0);
      chk({tag, "_init_w"}, bus.init_w_axi_txn, 0);
      chk({tag, "_init_r"}, bus.init_r_axi_txn, 0);
      chk({tag, "_user_awaddr"}, bus.user_awaddr, 0);
      chk({tag, "_user_araddr"}, bus.user_araddr, 0);
      chk({tag, "_user_wdata"}, bus.user_wdata, 0);
   endtask

   task automatic load_plan_cmds();
      vld = 2'b11;
      we_r[0] = 1; addr[0] = 32'h40; wd[0] = 32'hA5A5_0001;
      we_r[1] = 0; addr[1] = 32'h80; wd[1] = 32'h0;
   endtask

   initial begin
      vld = '0; we_r = '0;
      for (int i = 0; i < N; i++) begin addr[i] = '0; wd[i] = '0; end
      auto_gen = 0; p_new = 0; force_we = -1; force_kind = -1; rd_force_en = 0; rd_force = '0;
      model_reset();
      load_plan_cmds();
      apply();
      #12;
      chk_zero("reset");
      vld = '0;
      apply();
      @(negedge clk);
      rst = 0;
      // single write req0 then single read req1 returning 0x12345678
      load_plan_cmds();
      force_kind = 0; rd_force_en = 1; rd_force = 32'h1234_5678;
      drain();
      // continuous back-to-back writes from both requesters
      rd_force_en = 0; auto_gen = 1; p_new = 100; force_we = 1;
      repeat (80) step();
      auto_gen = 0;
      drain();
      // slave error read followed by OKAY read
      vld[0] = 1; we_r[0] = 0; addr[0] = $urandom; force_kind = 1;
      drain();
      vld[0] = 1; addr[0] = $urandom; force_kind = 0;
      drain();
      // unresponsive slave, then a normal request
      vld[1] = 1; we_r[1] = 1; addr[1] = $urandom; wd[1] = $urandom; force_kind = 2;
      drain();
      vld[0] = 1; we_r[0] = 0; force_kind = 0;
      drain();
      // random traffic
      auto_gen = 1; p_new = 40; force_we = -1; force_kind = -1;
      repeat (3000) step();
      auto_gen = 0;
      drain();
      // reset while waiting on a hung slave
      vld[0] = 1; we_r[0] = 0; addr[0] = $urandom; force_kind = 2;
      for (int i = 0; i < 50 && !(m_busy && cyc >= init_at + 3); i++) step();
      chk("pre_reset_busy", bus.busy, 1'b1);
      #2;
      rst = 1;
      model_reset();
      load_plan_cmds();
      apply();
      #1;
      chk_zero("midrst");
      vld = '0;
      apply();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 0;
      load_plan_cmds();
      force_kind = 0;
      drain();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
